// File: rtl/reg_bank_pkg.sv
// Shared types and defaults for the register bank arbiter.
package reg_bank_pkg;

  localparam int unsigned DEF_BUS_WIDTH = 15;
  localparam int unsigned DEF_NUM_REGS  = 31;
  localparam int unsigned DEF_ADDR_W    = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/reg_bank_arb_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that did not win last time is chosen.
module rr_arb2
  import reg_bank_pkg::*;
(
  input  logic    i_req_a,
  input  logic    i_req_b,
  input  req_id_e i_last_grant,
  output logic    o_grant_valid,
  output req_id_e o_grant_id
);

  always_comb begin
    o_grant_valid = i_req_a | i_req_b;
    o_grant_id    = REQ_A;
    if (i_req_a && i_req_b) begin
      o_grant_id = (i_last_grant == REQ_A) ? REQ_B : REQ_A;
    end else if (i_req_b) begin
      o_grant_id = REQ_B;
    end
  end

endmodule

// File: rtl/reg_bank_arb.sv
// Two-host round-robin controller sequencing setup/strobe/capture/done accesses to a register bank.
module reg_bank_arb
  import reg_bank_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = DEF_BUS_WIDTH,
  parameter int unsigned NUM_REGS  = DEF_NUM_REGS,
  parameter int unsigned ADDR_W    = DEF_ADDR_W
) (
  input  logic                sysclk,
  input  logic                resetb,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [BUS_WIDTH:0]  a_wdata,
  output logic                a_ack,
  output logic                a_err,
  output logic [BUS_WIDTH:0]  a_rdata,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [BUS_WIDTH:0]  b_wdata,
  output logic                b_ack,
  output logic                b_err,
  output logic [BUS_WIDTH:0]  b_rdata,
  output logic [NUM_REGS-1:0] reg_sel,
  output logic                reg_wrb,
  output logic [BUS_WIDTH:0]  reg_din,
  input  logic [BUS_WIDTH:0]  reg_rdout
);

  localparam logic [NUM_REGS-1:0] SEL_ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

  state_e              r_state, w_state_nxt;
  req_id_e             r_gnt, r_last_grant;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [BUS_WIDTH:0]  r_wdata;
  logic [BUS_WIDTH:0]  r_a_rdata, r_b_rdata;

  logic                w_grant_valid;
  req_id_e             w_grant_id;
  logic                w_addr_ok;
  logic [NUM_REGS-1:0] w_sel;
  logic                w_cap_en;
  logic [BUS_WIDTH:0]  w_cap_val;

  rr_arb2 u_rr_arb2 (
    .i_req_a       (a_req),
    .i_req_b       (b_req),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  assign w_addr_ok = (32'(r_addr) < NUM_REGS);
  assign w_sel     = w_addr_ok ? (SEL_ONE << r_addr) : '0;

  // Reads capture bank data; an out-of-range access of either kind clears the host's rdata.
  assign w_cap_en  = (r_state == CAPTURE) && (!w_addr_ok || !r_we);
  assign w_cap_val = w_addr_ok ? reg_rdout : '0;

  always_ff @(posedge sysclk or negedge resetb) begin
    if (!resetb) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge sysclk or negedge resetb) begin
    if (!resetb) begin
      r_gnt        <= REQ_A;
      r_last_grant <= REQ_B;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_a_rdata    <= '0;
      r_b_rdata    <= '0;
    end else begin
      if (r_state == IDLE && w_grant_valid) begin
        r_gnt   <= w_grant_id;
        r_we    <= (w_grant_id == REQ_B) ? b_we    : a_we;
        r_addr  <= (w_grant_id == REQ_B) ? b_addr  : a_addr;
        r_wdata <= (w_grant_id == REQ_B) ? b_wdata : a_wdata;
      end
      if (w_cap_en && r_gnt == REQ_A) begin
        r_a_rdata <= w_cap_val;
      end
      if (w_cap_en && r_gnt == REQ_B) begin
        r_b_rdata <= w_cap_val;
      end
      if (r_state == DONE) begin
        r_last_grant <= r_gnt;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    reg_sel     = '0;
    reg_wrb     = 1'b1;
    a_ack       = 1'b0;
    b_ack       = 1'b0;
    a_err       = 1'b0;
    b_err       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        reg_sel     = w_sel;
        w_state_nxt = STROBE;
      end
      STROBE: begin
        reg_sel     = w_sel;
        reg_wrb     = ~(r_we & w_addr_ok);
        w_state_nxt = CAPTURE;
      end
      CAPTURE: begin
        reg_sel     = w_sel;
        w_state_nxt = DONE;
      end
      DONE: begin
        a_ack       = (r_gnt == REQ_A);
        b_ack       = (r_gnt == REQ_B);
        a_err       = (r_gnt == REQ_A) & ~w_addr_ok;
        b_err       = (r_gnt == REQ_B) & ~w_addr_ok;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign reg_din = r_wdata;
  assign a_rdata = r_a_rdata;
  assign b_rdata = r_b_rdata;

endmodule

// File: tb/tb_reg_bank_arb.sv
// Bench for reg_bank_arb: directed literal checks plus randomized traffic against a cycle-count model.
module tb_reg_bank_arb;

  localparam int unsigned BW = 15;
  localparam int unsigned NR = 31;
  localparam int unsigned AW = 5;

  logic          sysclk = 1'b0;
  logic          resetb = 1'b0;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [BW:0]   a_wdata, b_wdata, a_rdata, b_rdata, reg_din, reg_rdout;
  logic          a_ack, a_err, b_ack, b_err, reg_wrb;
  logic [NR-1:0] reg_sel;

  reg_bank_arb #(
    .BUS_WIDTH (BW),
    .NUM_REGS  (NR),
    .ADDR_W    (AW)
  ) dut (
    .sysclk    (sysclk),
    .resetb    (resetb),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_ack     (a_ack),
    .a_err     (a_err),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_ack     (b_ack),
    .b_err     (b_err),
    .b_rdata   (b_rdata),
    .reg_sel   (reg_sel),
    .reg_wrb   (reg_wrb),
    .reg_din   (reg_din),
    .reg_rdout (reg_rdout)
  );

  always #5 sysclk = ~sysclk;

  int n_err = 0;
  int n_chk = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a transaction is described by who/what was granted and how many cycles ago.
  bit          m_busy, m_who, m_last, m_we;
  int unsigned m_k;
  logic [AW-1:0] m_addr;
  logic [BW:0]   m_wdata, m_rd_a, m_rd_b;

  function automatic bit pick(input bit ra, input bit rb, input bit last);
    if (ra && rb) return !last;
    return !ra;
  endfunction

  function automatic bit m_valid();
    return 32'(m_addr) < NR;
  endfunction

  always @(posedge sysclk or negedge resetb) begin
    if (!resetb) begin
      m_busy  <= 1'b0;
      m_k     <= 0;
      m_who   <= 1'b0;
      m_last  <= 1'b1;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_rd_a  <= '0;
      m_rd_b  <= '0;
    end else if (!m_busy) begin
      if (a_req || b_req) begin
        m_busy  <= 1'b1;
        m_k     <= 1;
        m_who   <= pick(a_req, b_req, m_last);
        m_we    <= pick(a_req, b_req, m_last) ? b_we : a_we;
        m_addr  <= pick(a_req, b_req, m_last) ? b_addr : a_addr;
        m_wdata <= pick(a_req, b_req, m_last) ? b_wdata : a_wdata;
      end
    end else begin
      if (m_k == 3 && (!m_valid() || !m_we)) begin
        if (m_who) m_rd_b <= m_valid() ? reg_rdout : '0;
        else       m_rd_a <= m_valid() ? reg_rdout : '0;
      end
      if (m_k == 4) begin
        m_busy <= 1'b0;
        m_last <= m_who;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  always @(negedge sysclk) begin
    if (chk_en) begin
      bit mid, done;
      mid  = m_busy && m_k >= 1 && m_k <= 3;
      done = m_busy && m_k == 4;
      check("sel", 32'(reg_sel), (mid && m_valid()) ? (32'd1 << m_addr) : 32'd0);
      check("wrb", 32'(reg_wrb), 32'(!(m_busy && m_k == 2 && m_we && m_valid())));
      check("a_ack", 32'(a_ack), 32'(done && !m_who));
      check("b_ack", 32'(b_ack), 32'(done && m_who));
      check("a_err", 32'(a_err), 32'(done && !m_who && !m_valid()));
      check("b_err", 32'(b_err), 32'(done && m_who && !m_valid()));
      check("a_rdata", 32'(a_rdata), 32'(m_rd_a));
      check("b_rdata", 32'(b_rdata), 32'(m_rd_b));
      if (mid) check("din", 32'(reg_din), 32'(m_wdata));
    end
  end

  // Observations of one directed transaction; index 0 is the IDLE cycle, 4 is DONE.
  logic [31:0] o_sel [5];
  logic        o_wrb [5];
  logic        o_ack [5];
  logic        o_err [5];
  logic [BW:0] o_din [5];
  logic [BW:0] o_rd  [5];

  task automatic xact(input bit h, input bit we, input logic [AW-1:0] ad, input logic [BW:0] wd);
    @(posedge sysclk); #1;
    if (!h) begin a_req = 1; a_we = we; a_addr = ad; a_wdata = wd; end
    else    begin b_req = 1; b_we = we; b_addr = ad; b_wdata = wd; end
    for (int c = 0; c < 5; c++) begin
      @(negedge sysclk);
      o_sel[c] = 32'(reg_sel);
      o_wrb[c] = reg_wrb;
      o_din[c] = reg_din;
      o_ack[c] = h ? b_ack : a_ack;
      o_err[c] = h ? b_err : a_err;
      o_rd[c]  = h ? b_rdata : a_rdata;
    end
    @(posedge sysclk); #1;
    if (!h) a_req = 0; else b_req = 0;
  endtask

  task automatic pulse_reset();
    @(negedge sysclk); #2 resetb = 0;
    @(negedge sysclk); #2 resetb = 1;
  endtask

  task automatic pair_run(output int ca, output int cb);
    bit sa, sb;
    ca = -1;
    cb = -1;
    @(posedge sysclk); #1;
    a_req = 1;
    b_req = 1;
    for (int c = 0; c < 25; c++) begin
      @(negedge sysclk);
      sa = a_ack;
      sb = b_ack;
      if (sa && ca < 0) ca = c;
      if (sb && cb < 0) cb = c;
      @(posedge sysclk); #1;
      if (sa) a_req = 0;
      if (sb) b_req = 0;
      if (ca >= 0 && cb >= 0) break;
    end
    a_req = 0;
    b_req = 0;
  endtask

  bit pend [2];

  task automatic agent_step(input int h, input bit seen);
    bit req, we, scr;
    logic [AW-1:0] ad;
    logic [BW:0] wd;
    req = h[0] ? b_req : a_req;
    we  = h[0] ? b_we : a_we;
    ad  = h[0] ? b_addr : a_addr;
    wd  = h[0] ? b_wdata : a_wdata;
    scr = 0;
    if (seen) begin
      pend[h] = 0;
      req = 0;
    end else if (!pend[h]) begin
      if ($urandom_range(3) == 0) begin pend[h] = 1; req = 1; scr = 1; end
    end else begin
      req = ($urandom_range(7) != 0);
      scr = ($urandom_range(3) == 0);
    end
    if (scr) begin
      we = 1'($urandom_range(1));
      ad = AW'($urandom_range(31));
      wd = BW'($urandom) | {($urandom_range(1) == 1), {BW{1'b0}}};
    end
    if (h[0]) begin b_req = req; b_we = we; b_addr = ad; b_wdata = wd; end
    else      begin a_req = req; a_we = we; a_addr = ad; a_wdata = wd; end
  endtask

  initial begin
    int ca, cb, nack, cyc, last_cyc;
    bit sa, sb;
    logic [5:0] seq;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    reg_rdout = '0;
    resetb = 0;
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    check("rst_sel", 32'(reg_sel), 32'd0);
    check("rst_wrb", 32'(reg_wrb), 32'd1);
    check("rst_din", 32'(reg_din), 32'd0);
    check("rst_acks", {28'd0, a_ack, b_ack, a_err, b_err}, 32'd0);
    check("rst_rdata", {a_rdata, b_rdata}, 32'd0);
    chk_en = 1;
    #2 resetb = 1;

    // A write to register 3.
    xact(1'b0, 1'b1, 5'd3, 16'h1234);
    check("t1_sel_setup", o_sel[1], 32'h0000_0008);
    check("t1_sel_capture", o_sel[3], 32'h0000_0008);
    check("t1_sel_done", o_sel[4], 32'd0);
    check("t1_din", 32'(o_din[1]), 32'h1234);
    check("t1_wrb", {29'd0, o_wrb[1], o_wrb[2], o_wrb[3]}, 32'b101);
    check("t1_ack", {30'd0, o_ack[3], o_ack[4]}, 32'b01);
    check("t1_err", 32'(o_err[4]), 32'd0);

    // B read from register 7.
    reg_rdout = 16'hBEEF;
    xact(1'b1, 1'b0, 5'd7, 16'h0000);
    check("t2_sel", o_sel[2], 32'h0000_0080);
    check("t2_wrb", {29'd0, o_wrb[1], o_wrb[2], o_wrb[3]}, 32'b111);
    check("t2_ack", 32'(o_ack[4]), 32'd1);
    check("t2_rdata", 32'(o_rd[4]), 32'hBEEF);
    check("t2_a_rdata", 32'(a_rdata), 32'd0);

    // Simultaneous requests after reset: A first, then again after B.
    pulse_reset();
    a_we = 1; a_addr = 5'd1; a_wdata = 16'h1111;
    b_we = 1; b_addr = 5'd2; b_wdata = 16'h2222;
    pair_run(ca, cb);
    check("t3_a_first", 32'(ca), 32'd4);
    check("t3_b_next", 32'(cb), 32'd9);
    pair_run(ca, cb);
    check("t3_a_again", 32'(ca), 32'd4);
    check("t3_b_again", 32'(cb), 32'd9);

    // Both hosts keep re-requesting: acks must alternate every five cycles.
    pulse_reset();
    @(posedge sysclk); #1;
    a_req = 1;
    b_req = 1;
    nack = 0; cyc = -1; last_cyc = -1; seq = '0;
    while (nack < 6 && cyc < 60) begin
      @(negedge sysclk);
      cyc++;
      sa = a_ack;
      sb = b_ack;
      if (sa) begin seq[nack] = 1'b0; nack++; last_cyc = cyc; end
      if (sb && nack < 6) begin seq[nack] = 1'b1; nack++; last_cyc = cyc; end
      @(posedge sysclk); #1;
      if (sa) a_req = 0; else if (!a_req && nack < 6) a_req = 1;
      if (sb) b_req = 0; else if (!b_req && nack < 6) b_req = 1;
    end
    a_req = 0;
    b_req = 0;
    check("t4_order", 32'(seq), 32'b101010);
    check("t4_last_ack", 32'(last_cyc), 32'd29);
    repeat (6) @(posedge sysclk);
    #1;

    // Good read then out-of-range read on A.
    reg_rdout = 16'h5A5A;
    xact(1'b0, 1'b0, 5'd5, 16'h0000);
    check("t5_rd_ok", 32'(o_rd[4]), 32'h5A5A);
    xact(1'b0, 1'b0, 5'd31, 16'h0000);
    check("t5_sel", o_sel[1] | o_sel[2] | o_sel[3], 32'd0);
    check("t5_wrb", {29'd0, o_wrb[1], o_wrb[2], o_wrb[3]}, 32'b111);
    check("t5_ack_err", {30'd0, o_ack[4], o_err[4]}, 32'b11);
    check("t5_rd_clr", 32'(o_rd[4]), 32'd0);

    // Reset during the strobe of a write, then a clean B write.
    @(posedge sysclk); #1;
    a_req = 1; a_we = 1; a_addr = 5'd9; a_wdata = 16'hA5A5;
    for (int c = 0; c < 3; c++) @(negedge sysclk);
    check("t6_strobe", {31'd0, reg_wrb}, 32'd0);
    #2 resetb = 0;
    #1;
    check("t6_rst_sel", 32'(reg_sel), 32'd0);
    check("t6_rst_wrb", 32'(reg_wrb), 32'd1);
    check("t6_rst_ack", 32'(a_ack), 32'd0);
    a_req = 0;
    repeat (2) @(negedge sysclk);
    #2 resetb = 1;
    xact(1'b1, 1'b1, 5'd0, 16'h0F0F);
    check("t6_b_sel", o_sel[1], 32'd1);
    check("t6_b_din", 32'(o_din[1]), 32'h0F0F);
    check("t6_b_wrb", 32'(o_wrb[2]), 32'd0);
    check("t6_b_ack", {30'd0, o_ack[4], o_err[4]}, 32'b10);

    // Randomized traffic checked by the model every cycle.
    pend[0] = 0;
    pend[1] = 0;
    repeat (3000) begin
      @(negedge sysclk);
      sa = a_ack;
      sb = b_ack;
      @(posedge sysclk); #1;
      reg_rdout = BW'($urandom) | {($urandom_range(1) == 1), {BW{1'b0}}};
      agent_step(0, sa);
      agent_step(1, sb);
    end
    a_req = 0;
    b_req = 0;
    repeat (8) @(posedge sysclk);
    @(negedge sysclk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
